// File: rtl/fpu_mul_arbiter_if.sv
// Request, multiplier and response bundle for fpu_mul_arbiter.
// slave is the arbiter side; master is the front-end/consumer side.
interface fpu_mul_arbiter_if #(
  parameter int BIT_WIDTH = 128,
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 32
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ-1:0]           o_req_ready;
  logic [3*NUM_REQ-1:0]         i_req_mode;
  logic [BIT_WIDTH*NUM_REQ-1:0] i_req_a;
  logic [BIT_WIDTH*NUM_REQ-1:0] i_req_b;
  logic [2:0]                   o_mul_mode;
  logic [BIT_WIDTH-1:0]         o_mul_a;
  logic [BIT_WIDTH-1:0]         o_mul_b;
  logic [BIT_WIDTH-1:0]         i_mul_result;
  logic                         i_mul_inexact;
  logic                         o_rsp_valid;
  logic                         i_rsp_ready;
  logic [ID_WIDTH-1:0]          o_rsp_id;
  logic [BIT_WIDTH-1:0]         o_rsp_data;
  logic                         o_rsp_inexact;
  logic                         o_busy;
  logic [CNT_WIDTH-1:0]         o_issue_count;

  modport slave (
    input  i_req_valid, i_req_mode, i_req_a, i_req_b,
    input  i_mul_result, i_mul_inexact, i_rsp_ready,
    output o_req_ready, o_mul_mode, o_mul_a, o_mul_b,
    output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_inexact,
    output o_busy, o_issue_count
  );

  modport master (
    output i_req_valid, i_req_mode, i_req_a, i_req_b,
    output i_mul_result, i_mul_inexact, i_rsp_ready,
    input  o_req_ready, o_mul_mode, o_mul_a, o_mul_b,
    input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_inexact,
    input  o_busy, o_issue_count
  );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Round-robin issue controller sharing one combinational fpu_mul
// between NUM_REQ requesters, with issue and response registers.
module fpu_mul_arbiter #(
  parameter int BIT_WIDTH = 128,
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 32
) (
  input logic              i_clk,
  input logic              i_reset,
  fpu_mul_arbiter_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  typedef logic [ID_WIDTH-1:0] id_t;

  logic                 s1Valid;
  id_t                  s1Id;
  logic [2:0]           s1Mode;
  logic [BIT_WIDTH-1:0] s1A;
  logic [BIT_WIDTH-1:0] s1B;
  logic                 rspValid;
  id_t                  rspId;
  logic [BIT_WIDTH-1:0] rspData;
  logic                 rspInexact;
  id_t                  rrPtr;
  logic [CNT_WIDTH-1:0] issueCount;

  logic                 s2Free;
  logic                 s1Free;
  logic                 advance;
  logic                 accept;
  logic                 found;
  id_t                  winner;
  id_t                  probe;
  id_t                  nextPtr;
  logic [NUM_REQ-1:0]   grant;

  assign s2Free  = !rspValid || bus.i_rsp_ready;
  assign s1Free  = !s1Valid || s2Free;
  assign advance = s1Valid && s2Free;
  assign accept  = found && s1Free && !i_reset;

  // first valid requester at or after rrPtr, modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = rrPtr;
    probe  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe = id_t'((int'(rrPtr) + i) % NUM_REQ);
      if (!found && bus.i_req_valid[probe]) begin
        found  = 1'b1;
        winner = probe;
      end
    end
  end

  always_comb begin
    grant         = '0;
    grant[winner] = accept;
  end

  assign nextPtr = (winner == id_t'(NUM_REQ - 1)) ?
                   '0 : winner + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1Valid    <= 1'b0;
      s1Id       <= '0;
      s1Mode     <= '0;
      s1A        <= '0;
      s1B        <= '0;
      rspValid   <= 1'b0;
      rspId      <= '0;
      rspData    <= '0;
      rspInexact <= 1'b0;
      rrPtr      <= '0;
      issueCount <= '0;
    end else begin
      if (accept) begin
        s1Valid    <= 1'b1;
        s1Id       <= winner;
        s1Mode     <= bus.i_req_mode[winner*3 +: 3];
        s1A        <= bus.i_req_a[winner*BIT_WIDTH +: BIT_WIDTH];
        s1B        <= bus.i_req_b[winner*BIT_WIDTH +: BIT_WIDTH];
        rrPtr      <= nextPtr;
        issueCount <= issueCount + 1'b1;
      end else if (advance) begin
        s1Valid <= 1'b0;
      end
      // a drain and an advance in the same cycle keep S2 full
      if (advance) begin
        rspValid   <= 1'b1;
        rspId      <= s1Id;
        rspData    <= bus.i_mul_result;
        rspInexact <= bus.i_mul_inexact;
      end else if (bus.i_rsp_ready) begin
        rspValid <= 1'b0;
      end
    end
  end

  assign bus.o_req_ready   = grant;
  assign bus.o_mul_mode    = s1Mode;
  assign bus.o_mul_a       = s1A;
  assign bus.o_mul_b       = s1B;
  assign bus.o_rsp_valid   = rspValid;
  assign bus.o_rsp_id      = rspId;
  assign bus.o_rsp_data    = rspData;
  assign bus.o_rsp_inexact = rspInexact;
  assign bus.o_busy        = s1Valid || rspValid;
  assign bus.o_issue_count = issueCount;
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter with a truncating FP32
// multiplier stub and a queue-based reference model.
module tb_fpu_mul_arbiter;
  localparam int BW = 32;
  localparam int NR = 4;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFail;
  int   cyc;

  fpu_mul_arbiter_if #(
    .BIT_WIDTH(BW), .NUM_REQ(NR), .CNT_WIDTH(CW)
  ) bus ();

  fpu_mul_arbiter #(
    .BIT_WIDTH(BW), .NUM_REQ(NR), .CNT_WIDTH(CW)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {inexact, product}; mode is folded into the top bits so
  // that a wrong mode routing changes the visible result
  function automatic logic [32:0] fmul(
    input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] f;
    logic        lost;
    logic [31:0] r;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      f    = p[46:24];
      lost = |p[23:0];
      e    = e + 10'd1;
    end else begin
      f    = p[45:23];
      lost = |p[22:0];
    end
    r = {a[31] ^ b[31], e[7:0], f} ^ {m, 29'b0};
    return {lost, r};
  endfunction

  always_comb
    {bus.i_mul_inexact, bus.i_mul_result} =
      fmul(bus.o_mul_mode, bus.o_mul_a, bus.o_mul_b);

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        inx;
    int          elig;
  } exp_t;

  exp_t            q[$];
  int              grantLog[$];
  int              mPtr;
  logic [CW-1:0]   mCnt;
  logic [NR-1:0]   accVec;

  // Reference: at most two products in flight; a slot frees in
  // the cycle the response drains. Grant goes to the first valid
  // requester after the previous winner. Response visible two
  // cycles after accept, or one cycle after the previous drain.
  always @(negedge clk) begin
    logic [NR-1:0] expRdy;
    logic          free;
    logic          expVal;
    logic          hit;
    int            k;
    exp_t          e;
    accVec = '0;
    if (rst) begin
      check("ready_in_reset", 64'(bus.o_req_ready), 64'd0);
      q.delete();
      mPtr = 0;
      mCnt = '0;
    end else begin
      free   = (q.size() < 2) || bus.i_rsp_ready;
      expRdy = '0;
      hit    = 1'b0;
      if (free) begin
        for (int off = 0; off < NR; off++) begin
          k = (mPtr + off) % NR;
          if (!hit && bus.i_req_valid[k]) begin
            hit       = 1'b1;
            expRdy[k] = 1'b1;
          end
        end
      end
      check("req_ready", 64'(bus.o_req_ready), 64'(expRdy));
      expVal = (q.size() > 0) && (q[0].elig <= cyc);
      check("rsp_valid", 64'(bus.o_rsp_valid), 64'(expVal));
      check("busy", 64'(bus.o_busy), 64'(q.size() > 0));
      check("issue_count", 64'(bus.o_issue_count), 64'(mCnt));
      if (bus.o_rsp_valid && expVal) begin
        check("rsp_id", 64'(bus.o_rsp_id), 64'(q[0].id));
        check("rsp_data", 64'(bus.o_rsp_data), 64'(q[0].data));
        check("rsp_inexact", 64'(bus.o_rsp_inexact), 64'(q[0].inx));
        if (bus.i_rsp_ready) begin
          void'(q.pop_front());
          if (q.size() > 0 && q[0].elig < cyc + 1)
            q[0].elig = cyc + 1;
        end
      end
      accVec = expRdy & bus.i_req_valid;
      for (int j = 0; j < NR; j++) begin
        if (accVec[j]) begin
          {e.inx, e.data} = fmul(bus.i_req_mode[3*j +: 3],
                                 bus.i_req_a[BW*j +: BW],
                                 bus.i_req_b[BW*j +: BW]);
          e.id   = j;
          e.elig = cyc + 2;
          q.push_back(e);
          grantLog.push_back(j);
          mPtr = (j + 1) % NR;
          mCnt = mCnt + 1'b1;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++)
      if (accVec[k]) bus.i_req_valid[k] = 1'b0;
  endtask

  task automatic newReq(input int k, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] b);
    bus.i_req_valid[k]       = 1'b1;
    bus.i_req_mode[3*k +: 3] = m;
    bus.i_req_a[BW*k +: BW]  = a;
    bus.i_req_b[BW*k +: BW]  = b;
  endtask

  task automatic randReq(input int k);
    newReq(k, 3'($urandom_range(0, 4)), $urandom, $urandom);
  endtask

  task automatic waitAcc(input int k);
    int n;
    n = 0;
    while (bus.i_req_valid[k] && n < 20) begin
      tick();
      n++;
    end
    check("accept_timeout", 64'(bus.i_req_valid[k]), 64'd0);
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    cyc     = 0;
    mPtr    = 0;
    mCnt    = '0;
    accVec  = '0;
    rst              = 1'b1;
    bus.i_req_valid  = '0;
    bus.i_req_mode   = '0;
    bus.i_req_a      = '0;
    bus.i_req_b      = '0;
    bus.i_rsp_ready  = 1'b0;
    tick();
    tick();
    check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_count", 64'(bus.o_issue_count), 64'd0);
    check("rst_mul_a", 64'(bus.o_mul_a), 64'd0);
    check("rst_rsp_data", 64'(bus.o_rsp_data), 64'd0);
    rst = 1'b0;

    // single op: 3.0 * 2.0
    bus.i_rsp_ready = 1'b1;
    newReq(0, 3'd0, 32'h4040_0000, 32'h4000_0000);
    tick();
    check("single_t1_valid", 64'(bus.o_rsp_valid), 64'd0);
    tick();
    check("single_valid", 64'(bus.o_rsp_valid), 64'd1);
    check("single_id", 64'(bus.o_rsp_id), 64'd0);
    check("single_data", 64'(bus.o_rsp_data), 64'h40C0_0000);
    check("single_inexact", 64'(bus.o_rsp_inexact), 64'd0);
    check("single_count", 64'(bus.o_issue_count), 64'd1);
    tick();

    // fairness: everyone requesting continuously, pointer at 1
    grantLog.delete();
    for (int k = 0; k < NR; k++) randReq(k);
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int k = 0; k < NR; k++)
        if (!bus.i_req_valid[k]) randReq(k);
    end
    for (int i = 0; i < 8; i++)
      check("fair_order", 64'(grantLog[i]), 64'((i + 1) % NR));
    for (int c = 0; c < 8; c++) tick();

    // backpressure: two fit, the third waits for the drain
    bus.i_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) randReq(k);
    for (int c = 0; c < 5; c++) tick();
    check("bp_ready", 64'(bus.o_req_ready), 64'd0);
    check("bp_pending", 64'($countones(bus.i_req_valid)), 64'd1);
    bus.i_rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();

    // pointer: grant to 1, then 2 beats 1
    grantLog.delete();
    randReq(1);
    waitAcc(1);
    randReq(2);
    randReq(1);
    waitAcc(1);
    check("prio_n", 64'(grantLog.size()), 64'd3);
    if (grantLog.size() == 3) begin
      check("prio_first", 64'(grantLog[1]), 64'd2);
      check("prio_second", 64'(grantLog[2]), 64'd1);
    end
    for (int c = 0; c < 4; c++) tick();

    // reset with both stages full
    bus.i_rsp_ready = 1'b0;
    randReq(0);
    randReq(3);
    for (int c = 0; c < 4; c++) tick();
    check("full_busy", 64'(bus.o_busy), 64'd1);
    bus.i_req_valid = '0;
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(bus.o_rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.o_busy), 64'd0);
    check("mid_rst_count", 64'(bus.o_issue_count), 64'd0);
    rst = 1'b0;
    bus.i_rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();

    // counter wraps after 16 accepts
    for (int i = 0; i < 17; i++) begin
      randReq(i % NR);
      waitAcc(i % NR);
    end
    check("wrap_count", 64'(bus.o_issue_count), 64'd1);
    for (int c = 0; c < 4; c++) tick();

    // random traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      tick();
      bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NR; k++)
        if (!bus.i_req_valid[k] && $urandom_range(0, 1) == 1)
          randReq(k);
    end
    bus.i_rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) tick();
    check("drain_busy", 64'(bus.o_busy), 64'd0);
    check("drain_left", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end
endmodule
